// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-domain pointer, read-pointer synchroniser, full/almost-full and fill level of an async FIFO
module fifo_wptr_full #(
  parameter int ADDR_W       = 4,
  parameter int AFULL_THRESH = (1 << ADDR_W) - 2
) (
  input  logic              i_wclk,
  input  logic              i_wrst,
  input  logic              i_winc,
  input  logic [ADDR_W:0]   i_rptr,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [ADDR_W:0]   o_wptr,
  output logic              o_wfull,
  output logic              o_wAlmostFull,
  output logic [ADDR_W:0]   o_wlevel
);
  localparam logic [ADDR_W:0] AF = (ADDR_W+1)'(AFULL_THRESH);
  logic [ADDR_W:0] wbin, wgray, rq1, rq2, wbin_next, wgray_next, rbin;
  logic            wfull, wr;
  always_comb begin
    wr         = i_winc & ~wfull;
    wbin_next  = wbin + {{ADDR_W{1'b0}}, wr};
    wgray_next = (wbin_next >> 1) ^ wbin_next;
    for (int i = 0; i <= ADDR_W; i++) rbin[i] = ^(rq2 >> i);
  end
  // full compares the next Gray pointer with the synchronised read pointer, so it is never late
  always_ff @(posedge i_wclk) begin
    if (i_wrst) begin
      {wbin, wgray, rq1, rq2} <= '0;
      wfull                   <= 1'b0;
    end else begin
      wbin  <= wbin_next;
      wgray <= wgray_next;
      rq1   <= i_rptr;
      rq2   <= rq1;
      wfull <= wgray_next == {~rq2[ADDR_W:ADDR_W-1], rq2[ADDR_W-2:0]};
    end
  end
  assign o_waddr       = wbin[ADDR_W-1:0];
  assign o_wptr        = wgray;
  assign o_wfull       = wfull;
  assign o_wlevel      = wbin - rbin;
  assign o_wAlmostFull = o_wlevel >= AF;
endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb_fifo_wptr_full: directed self-checking bench for the async FIFO write-side pointer block
module tb_fifo_wptr_full;
  logic       clk = 1'b0, rst = 1'b0, winc = 1'b0;
  logic [4:0] rptr = '0;
  logic [3:0] waddr;
  logic [4:0] wptr, wlevel;
  logic       wfull, waf;
  int checks = 0, errors = 0;

  fifo_wptr_full #(.ADDR_W(4), .AFULL_THRESH(14)) dut (
    .i_wclk(clk), .i_wrst(rst), .i_winc(winc), .i_rptr(rptr),
    .o_waddr(waddr), .o_wptr(wptr), .o_wfull(wfull),
    .o_wAlmostFull(waf), .o_wlevel(wlevel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    winc = 1'b0;
    rptr = '0;
    tick();
    rst = 1'b0;
  endtask

  int mw, r_total, nacc, wraps, lag;
  logic [4:0] rq1m, rq2m, lv, d, rb, prevptr;
  logic [3:0] prevaddr;
  logic       fullm, acc, wi;

  initial begin
    // 1 reset overrides write
    rst = 1'b1; winc = 1'b1;
    tick(); tick();
    rst = 1'b0; winc = 1'b0;
    chk("rst_waddr", waddr, 0);
    chk("rst_wptr", wptr, 0);
    chk("rst_wfull", wfull, 0);
    chk("rst_wlevel", wlevel, 0);
    chk("rst_afull", waf, 0);

    // 2 fill
    winc = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 13) chk("fill13_afull", waf, 0);
      if (i == 14) begin
        chk("fill14_afull", waf, 1);
        chk("fill14_level", wlevel, 14);
      end
      if (i == 15) chk("fill15_full", wfull, 0);
    end
    chk("fill_full", wfull, 1);
    chk("fill_level", wlevel, 16);
    chk("fill_wptr", wptr, 5'b11000);
    chk("fill_waddr", waddr, 0);

    // 3 overrun is ignored
    tick(); tick(); tick();
    chk("ovr_wptr", wptr, 5'b11000);
    chk("ovr_waddr", waddr, 0);
    chk("ovr_level", wlevel, 16);
    chk("ovr_full", wfull, 1);

    // 4 drain one entry
    winc = 1'b0; rptr = 5'b00001;
    tick();
    chk("drain1_level", wlevel, 16);
    tick();
    chk("drain2_level", wlevel, 15);
    chk("drain2_full", wfull, 1);
    tick();
    chk("drain3_full", wfull, 0);
    winc = 1'b1;
    tick();
    winc = 1'b0;
    chk("refill_full", wfull, 1);
    chk("refill_level", wlevel, 16);
    chk("refill_waddr", waddr, 1);

    // 5 wrap with a lagging reader
    do_reset();
    mw = 0; r_total = 0; nacc = 0; wraps = 0;
    rq1m = '0; rq2m = '0; fullm = 1'b0;
    prevptr = wptr; prevaddr = waddr;
    winc = 1'b1; wi = 1'b1; rb = '0; rptr = '0;
    for (int cyc = 0; cyc < 200 && nacc < 40; cyc++) begin
      tick();
      acc = wi & ~fullm;
      d = 5'(mw + int'(acc)) - rq2m;
      fullm = (d == 5'd16);
      mw = mw + int'(acc);
      rq2m = rq1m;
      rq1m = rb;
      lv = 5'(mw) - rq2m;
      chk("wrap_full", wfull, fullm);
      chk("wrap_level", wlevel, lv);
      chk("wrap_hamming", $countones(wptr ^ prevptr), acc);
      if (wlevel > 5'd16) chk("wrap_level_max", wlevel, 16);
      if (prevaddr == 4'd15 && waddr == 4'd0) wraps++;
      if (wptr != prevptr) nacc++;
      prevptr = wptr; prevaddr = waddr;
      lag = $urandom_range(1, 4);
      if (mw - r_total >= lag) r_total++;
      rb = 5'(r_total);
      rptr = rb ^ (rb >> 1);
      winc = (nacc < 40);
      wi = winc;
    end
    winc = 1'b0;
    chk("wrap_accepts", nacc, 40);
    chk("wrap_count", wraps, 2);

    // 6 reset mid-operation with a stale read pointer
    do_reset();
    rptr = 5'b00011;
    winc = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    winc = 1'b0;
    chk("mid_level9", wlevel, 9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_waddr", waddr, 0);
    chk("mid_rst_wptr", wptr, 0);
    chk("mid_rst_full", wfull, 0);
    chk("mid_rst_level", wlevel, 0);
    chk("mid_rst_afull", waf, 0);
    tick();
    chk("mid_resync1_level", wlevel, 0);
    tick();
    chk("mid_resync2_level", wlevel, 30);
    chk("mid_resync2_afull", waf, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
